// File: rtl/disp_scan_decoder_pkg.sv
// Package: disp_scan_decoder_pkg
// Shared definitions for the 7-segment scan decoder.
//  - Glyph constants: active-high segment patterns g..a for hex 0..F.
//  - Digit-index constants: SA / register bit position for each display digit.
//  - FSM state encodings and the strobe classification helper.
package disp_scan_decoder_pkg;

  // Segment patterns, bit 0 = a .. bit 6 = g, active-high
  localparam logic [6:0] GLYPH_0 = 7'h3F;
  localparam logic [6:0] GLYPH_1 = 7'h06;
  localparam logic [6:0] GLYPH_2 = 7'h5B;
  localparam logic [6:0] GLYPH_3 = 7'h4F;
  localparam logic [6:0] GLYPH_4 = 7'h66;
  localparam logic [6:0] GLYPH_5 = 7'h6D;
  localparam logic [6:0] GLYPH_6 = 7'h7D;
  localparam logic [6:0] GLYPH_7 = 7'h07;
  localparam logic [6:0] GLYPH_8 = 7'h7F;
  localparam logic [6:0] GLYPH_9 = 7'h6F;
  localparam logic [6:0] GLYPH_A = 7'h77;
  localparam logic [6:0] GLYPH_B = 7'h7C;
  localparam logic [6:0] GLYPH_C = 7'h39;
  localparam logic [6:0] GLYPH_D = 7'h5E;
  localparam logic [6:0] GLYPH_E = 7'h79;
  localparam logic [6:0] GLYPH_F = 7'h71;

  // Digit 1 is the leftmost digit and is strobed by SA[3]
  localparam int DIGIT1_IDX = 3;
  localparam int DIGIT2_IDX = 2;
  localparam int DIGIT3_IDX = 1;
  localparam int DIGIT4_IDX = 0;

  // FSM encodings; the remaining 3-bit codes are illegal and recover to BLANK
  localparam logic [2:0] ST_BLANK  = 3'd0;
  localparam logic [2:0] ST_SETTLE = 3'd1;
  localparam logic [2:0] ST_HELD   = 3'd2;
  localparam logic [2:0] ST_FAULT  = 3'd3;

  // State entered when a new strobe value is seen
  function automatic logic [2:0] classify_sa(input logic [3:0] sa);
    if (sa == 4'b0000)
      return ST_BLANK;
    else if ((sa & (sa - 4'd1)) == 4'b0000)
      return ST_SETTLE;
    else
      return ST_FAULT;
  endfunction

endpackage

// File: rtl/disp_scan_decoder_if.sv
// Interface: disp_scan_decoder_if
// The multiplexed display bus as seen on the board.
//  SA : 4-bit one-hot digit strobe (SA[3] = digit 1 .. SA[0] = digit 4)
//  L  : 8-bit segment byte (L[0] = a .. L[6] = g, L[7] = dp)
// master: the display driver side (drives the bus)
// slave : the scan decoder side (observes the bus)
interface disp_scan_decoder_if;
  logic [3:0] SA;
  logic [7:0] L;

  modport master (output SA, output L);
  modport slave  (input SA, input L);
endinterface

// File: rtl/disp_scan_decoder_seg7_to_hex.sv
// Module: seg7_to_hex
// Combinational 7-segment to hex decoder.
//  segs  in  8  segment byte in bus polarity (dp in bit 7 is ignored)
//  value out 4  decoded hex digit, 0 when the pattern is not a hex glyph
//  valid out 1  high when segs[6:0] matches one of the 16 hex glyphs
// SEG_ACT_LOW selects whether a lit segment is driven as 0 (1) or 1 (0).
module seg7_to_hex
  import disp_scan_decoder_pkg::*;
#(
  parameter bit SEG_ACT_LOW = 1'b1
) (
  input  logic [7:0] segs,
  output logic [3:0] value,
  output logic       valid
);

  logic [6:0] norm;
  logic       unused_dp;

  assign unused_dp = segs[7];

  // Normalise to active-high, then match against the glyph set
  always_comb begin
    norm  = SEG_ACT_LOW ? ~segs[6:0] : segs[6:0];
    value = 4'h0;
    valid = 1'b1;
    case (norm)
      GLYPH_0: value = 4'h0;
      GLYPH_1: value = 4'h1;
      GLYPH_2: value = 4'h2;
      GLYPH_3: value = 4'h3;
      GLYPH_4: value = 4'h4;
      GLYPH_5: value = 4'h5;
      GLYPH_6: value = 4'h6;
      GLYPH_7: value = 4'h7;
      GLYPH_8: value = 4'h8;
      GLYPH_9: value = 4'h9;
      GLYPH_A: value = 4'hA;
      GLYPH_B: value = 4'hB;
      GLYPH_C: value = 4'hC;
      GLYPH_D: value = 4'hD;
      GLYPH_E: value = 4'hE;
      GLYPH_F: value = 4'hF;
      default: begin
        value = 4'h0;
        valid = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/disp_scan_decoder.sv
// Module: disp_scan_decoder
// Receive end of a 4-digit multiplexed 7-segment bus. Samples the strobe and
// segment byte, waits for them to be stable, and rebuilds the four digit
// registers plus their hex decode.
//  CLK        in  1  clock, rising edge
//  RST        in  1  synchronous reset, active-high
//  bus        slave  SA (one-hot strobe) and L (segment byte)
//  D1..D4     out 8  last captured raw segment byte per digit
//  HEX1..HEX4 out 4  decoded value per digit (0 when not a glyph)
//  HEX_VALID  out 4  bit i set when digit (4-i) holds a hex glyph
//  FRAME_DONE out 1  pulse once all four digits have been captured
//  ERR        out 1  pulse when a multi-hot strobe is first seen
module disp_scan_decoder
  import disp_scan_decoder_pkg::*;
#(
  parameter int STABLE_CYCLES = 2,
  parameter bit SEG_ACT_LOW   = 1'b1
) (
  input  logic                CLK,
  input  logic                RST,
  disp_scan_decoder_if.slave  bus,
  output logic [7:0]          D1,
  output logic [7:0]          D2,
  output logic [7:0]          D3,
  output logic [7:0]          D4,
  output logic [3:0]          HEX1,
  output logic [3:0]          HEX2,
  output logic [3:0]          HEX3,
  output logic [3:0]          HEX4,
  output logic [3:0]          HEX_VALID,
  output logic                FRAME_DONE,
  output logic                ERR
);

  localparam int             CW      = (STABLE_CYCLES < 2) ? 1 : $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0]  CNT_MAX = CW'(STABLE_CYCLES);
  localparam logic [7:0]     UNLIT   = SEG_ACT_LOW ? 8'hFF : 8'h00;

  logic [3:0]    s_sa, p_sa;
  logic [7:0]    s_l,  p_l;
  logic [CW-1:0] cnt;
  logic [2:0]    state, state_nxt;
  logic [3:0]    mask, mask_nxt;
  logic [7:0]    d_reg   [4];
  logic [3:0]    hex_reg [4];
  logic [3:0]    valid_reg;
  logic          changed, capture, frame_full;
  logic [3:0]    dec_value;
  logic          dec_valid;

  seg7_to_hex #(.SEG_ACT_LOW(SEG_ACT_LOW)) u_dec (
    .segs  (s_l),
    .value (dec_value),
    .valid (dec_valid)
  );

  // p_* is the previous registered sample, so changed compares two
  // consecutive samples. A capture needs the count saturated and the
  // current sample still equal, so the captured byte is the stable one.
  always_comb begin
    changed    = {s_sa, s_l} != {p_sa, p_l};
    capture    = !changed && (state == ST_SETTLE) && (cnt == CNT_MAX);
    frame_full = (mask == 4'hF);
    mask_nxt   = (frame_full ? 4'h0 : mask) | (capture ? s_sa : 4'h0);
  end

  // Any change re-classifies the strobe; otherwise only SETTLE advances
  always_comb begin
    state_nxt = state;
    if (changed) begin
      state_nxt = classify_sa(s_sa);
    end else begin
      case (state)
        ST_BLANK, ST_HELD, ST_FAULT: state_nxt = state;
        ST_SETTLE: if (cnt == CNT_MAX) state_nxt = ST_HELD;
        default:   state_nxt = ST_BLANK;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      s_sa       <= 4'b0000;
      p_sa       <= 4'b0000;
      s_l        <= UNLIT;
      p_l        <= UNLIT;
      cnt        <= '0;
      state      <= ST_BLANK;
      mask       <= 4'b0000;
      valid_reg  <= 4'b0000;
      FRAME_DONE <= 1'b0;
      ERR        <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        d_reg[i]   <= UNLIT;
        hex_reg[i] <= 4'h0;
      end
    end else begin
      s_sa       <= bus.SA;
      s_l        <= bus.L;
      p_sa       <= s_sa;
      p_l        <= s_l;
      state      <= state_nxt;
      mask       <= mask_nxt;
      FRAME_DONE <= frame_full;
      ERR        <= (state_nxt == ST_FAULT) && (state != ST_FAULT);
      if (changed)
        cnt <= CW'(1);
      else if (cnt != CNT_MAX)
        cnt <= cnt + CW'(1);
      for (int i = 0; i < 4; i++) begin
        if (capture && s_sa[i]) begin
          d_reg[i]     <= s_l;
          hex_reg[i]   <= dec_value;
          valid_reg[i] <= dec_valid;
        end
      end
    end
  end

  assign D1        = d_reg[DIGIT1_IDX];
  assign D2        = d_reg[DIGIT2_IDX];
  assign D3        = d_reg[DIGIT3_IDX];
  assign D4        = d_reg[DIGIT4_IDX];
  assign HEX1      = hex_reg[DIGIT1_IDX];
  assign HEX2      = hex_reg[DIGIT2_IDX];
  assign HEX3      = hex_reg[DIGIT3_IDX];
  assign HEX4      = hex_reg[DIGIT4_IDX];
  assign HEX_VALID = valid_reg;

endmodule

// File: tb/tb_disp_scan_decoder.sv
// Testbench: tb_disp_scan_decoder
// Drives the display bus with directed scans and random traffic and compares
// every cycle against a reference model built from the sampling rules:
// a digit is captured once a one-hot strobe/byte pair has been sampled
// STABLE+1 times in a row after a different sample.
module tb_disp_scan_decoder;

  localparam int STABLE = 2;
  localparam int K      = STABLE + 2;

  logic       CLK = 1'b0;
  logic       RST;
  logic [7:0] D1, D2, D3, D4;
  logic [3:0] HEX1, HEX2, HEX3, HEX4, HEX_VALID;
  logic       FRAME_DONE, ERR;

  always #5 CLK = ~CLK;

  disp_scan_decoder_if bus ();

  disp_scan_decoder #(.STABLE_CYCLES(STABLE), .SEG_ACT_LOW(1'b1)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .bus        (bus),
    .D1         (D1),
    .D2         (D2),
    .D3         (D3),
    .D4         (D4),
    .HEX1       (HEX1),
    .HEX2       (HEX2),
    .HEX3       (HEX3),
    .HEX4       (HEX4),
    .HEX_VALID  (HEX_VALID),
    .FRAME_DONE (FRAME_DONE),
    .ERR        (ERR)
  );

  int testCount = 0;
  int failCount = 0;
  int fdSeen    = 0;
  int errSeen   = 0;

  logic [6:0]  glyphs [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  logic [7:0]  expD [4];
  logic [3:0]  expMask;
  logic        expFd, expErr;
  logic [11:0] hist [$];

  // {valid, value} for an active-low segment byte
  function automatic logic [4:0] refDecode(input logic [7:0] seg);
    logic [6:0] lit;
    lit = ~seg[6:0];
    for (int g = 0; g < 16; g++)
      if (glyphs[g] == lit) return {1'b1, 4'(g)};
    return 5'b0_0000;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  // One clock edge of the reference model; hist holds the last K samples
  task automatic modelEdge(input logic [3:0] sa, input logic [7:0] l, input logic rst);
    logic [11:0] cur, prev;
    logic        cap;
    if (rst) begin
      for (int i = 0; i < 4; i++) expD[i] = 8'hFF;
      expMask = 4'b0000;
      expFd   = 1'b0;
      expErr  = 1'b0;
      hist.push_back(12'h000);
    end else begin
      cur  = hist[K-1];
      prev = hist[K-2];
      cap  = ($countones(cur[11:8]) == 1);
      for (int j = 1; j < K - 1; j++)
        if (hist[j] != cur) cap = 1'b0;
      if (hist[0] == cur) cap = 1'b0;
      expErr = (cur != prev) && ($countones(cur[11:8]) > 1) && ($countones(prev[11:8]) <= 1);
      expFd  = (expMask == 4'hF);
      if (expFd) expMask = 4'b0000;
      if (cap) begin
        for (int i = 0; i < 4; i++) begin
          if (cur[8+i]) begin
            expD[i]    = cur[7:0];
            expMask[i] = 1'b1;
          end
        end
      end
      hist.push_back({sa, l});
    end
    void'(hist.pop_front());
  endtask

  task automatic applyStimulus(input logic [3:0] sa, input logic [7:0] l, input logic rst);
    logic [4:0]  dec [4];
    logic [15:0] expHex;
    logic [3:0]  expValid;
    @(negedge CLK);
    bus.SA = sa;
    bus.L  = l;
    RST    = rst;
    @(posedge CLK);
    #1;
    modelEdge(sa, l, rst);
    for (int i = 0; i < 4; i++) dec[i] = refDecode(expD[i]);
    expHex   = {dec[3][3:0], dec[2][3:0], dec[1][3:0], dec[0][3:0]};
    expValid = {dec[3][4], dec[2][4], dec[1][4], dec[0][4]};
    checkOutput("D1..D4", {D1, D2, D3, D4}, {expD[3], expD[2], expD[1], expD[0]});
    checkOutput("HEX1..HEX4", {16'h0, HEX1, HEX2, HEX3, HEX4}, {16'h0, expHex});
    checkOutput("HEX_VALID", {28'h0, HEX_VALID}, {28'h0, expValid});
    checkOutput("FRAME_DONE", {31'h0, FRAME_DONE}, {31'h0, expFd});
    checkOutput("ERR", {31'h0, ERR}, {31'h0, expErr});
    if (FRAME_DONE === 1'b1) fdSeen++;
    if (ERR === 1'b1) errSeen++;
  endtask

  task automatic scan(input logic [3:0] sa, input logic [7:0] l, input int n);
    for (int c = 0; c < n; c++) applyStimulus(sa, l, 1'b0);
  endtask

  task automatic doReset(input int n);
    for (int c = 0; c < n; c++) applyStimulus(4'b0000, 8'hFF, 1'b1);
  endtask

  initial begin
    logic [3:0] rsa;
    logic [7:0] rl;
    int         r, hold;
    bus.SA = 4'b0000;
    bus.L  = 8'hFF;
    RST    = 1'b1;
    for (int k = 0; k < K; k++) hist.push_back(12'h000);

    // Reset state
    doReset(2);
    checkOutput("t1_D", {D1, D2, D3, D4}, 32'hFFFF_FFFF);
    checkOutput("t1_valid", {28'h0, HEX_VALID}, 32'h0);

    // Single digit capture
    fdSeen = 0;
    scan(4'b1000, 8'hF9, 4);
    checkOutput("t2_D1", {24'h0, D1}, 32'hF9);
    checkOutput("t2_HEX1", {28'h0, HEX1}, 32'h1);
    checkOutput("t2_valid", {28'h0, HEX_VALID}, 32'h8);
    checkOutput("t2_frames", fdSeen, 0);

    // Full scan
    fdSeen = 0;
    scan(4'b0001, 8'hC0, 3); scan(4'b0000, 8'hFF, 3);
    scan(4'b0010, 8'hA4, 3); scan(4'b0000, 8'hFF, 3);
    scan(4'b0100, 8'hB0, 3); scan(4'b0000, 8'hFF, 3);
    scan(4'b1000, 8'h99, 3); scan(4'b0000, 8'hFF, 3);
    checkOutput("t3_hex", {16'h0, HEX4, HEX3, HEX2, HEX1}, 32'h0234);
    checkOutput("t3_valid", {28'h0, HEX_VALID}, 32'hF);
    checkOutput("t3_frames", fdSeen, 1);

    // One-cycle glitch on digit 2
    scan(4'b0100, 8'h92, 1); scan(4'b0000, 8'hFF, 4);
    checkOutput("t4_D2", {24'h0, D2}, 32'hB0);

    // Multi-hot strobe
    errSeen = 0;
    scan(4'b0011, 8'hC0, 3);
    checkOutput("t5_errs", errSeen, 1);
    checkOutput("t5_D", {D1, D2, D3, D4}, 32'h99B0_A4C0);
    scan(4'b0001, 8'hF9, 3); scan(4'b0000, 8'hFF, 2);
    checkOutput("t5_D4", {24'h0, D4}, 32'hF9);

    // Partial frame discarded by reset
    doReset(2);
    scan(4'b1000, 8'hA4, 3); scan(4'b0000, 8'hFF, 1);
    scan(4'b0100, 8'hB0, 3); scan(4'b0000, 8'hFF, 1);
    scan(4'b0010, 8'h99, 3); scan(4'b0000, 8'hFF, 1);
    doReset(2);
    fdSeen = 0;
    scan(4'b1000, 8'hF9, 3); scan(4'b0000, 8'hFF, 1);
    scan(4'b0100, 8'hA4, 3); scan(4'b0000, 8'hFF, 1);
    scan(4'b0010, 8'hB0, 3); scan(4'b0000, 8'hFF, 3);
    checkOutput("t6_early_frames", fdSeen, 0);
    scan(4'b0001, 8'hFF, 3); scan(4'b0000, 8'hFF, 3);
    checkOutput("t6_frames", fdSeen, 1);
    checkOutput("t6_D4", {24'h0, D4}, 32'hFF);
    checkOutput("t6_valid0", {31'h0, HEX_VALID[0]}, 32'h0);
    checkOutput("t6_HEX4", {28'h0, HEX4}, 32'h0);

    // Random traffic
    for (int s = 0; s < 400; s++) begin
      r    = $urandom_range(0, 99);
      hold = $urandom_range(1, 5);
      if (r < 4) begin
        doReset($urandom_range(1, 2));
      end else begin
        if (r < 25) begin
          rsa = 4'b0000;
        end else if (r < 35) begin
          rsa = 4'($urandom_range(0, 15));
          while ($countones(rsa) < 2) rsa = 4'($urandom_range(0, 15));
        end else begin
          rsa = 4'b0001 << $urandom_range(0, 3);
        end
        if ($urandom_range(0, 9) < 7)
          rl = {1'($urandom_range(0, 1)), ~glyphs[$urandom_range(0, 15)]};
        else
          rl = 8'($urandom_range(0, 255));
        scan(rsa, rl, hold);
      end
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
